// File: rtl/x_ser_32_bit_pkg.sv
// x_ser_32_bit_pkg
// Shared types and constants for the x_ser_32_bit framed serial transmitter.
// The optional parity bit is controlled by the macro X_SER_32_BIT_PARITY_EN.

package x_ser_32_bit_pkg;

    // Frame sequencer states. PARITY is only reachable when the parity bit is built in.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        DATA   = 2'd2,
        PARITY = 2'd3
    } x_ser_state_t;

    // Default data word width carried by one frame.
    localparam int DEFAULT_WIDTH = 32;

    // Width of a counter that has to index every data bit of a WIDTH-bit word.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

    // Bit counter width for the default word width.
    localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/x_ser_32_bit.sv
// x_ser_32_bit
// Parallel-in, serial-out framed transmitter. A word accepted on a valid/ready
// handshake leaves as a start bit followed by the data MSB first, one bit per
// clock, so that bit WIDTH-1 ends up deepest in the downstream shift register.
// Define X_SER_32_BIT_PARITY_EN to append an even parity bit to every frame.

module x_ser_32_bit
    import x_ser_32_bit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    output logic             o_out,
    output logic             o_busy
);

    localparam int                CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

    x_ser_state_t     state_q;
    x_ser_state_t     state_d;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             out_q;
    logic             out_d;
    logic             last_data;
    logic             transfer;
`ifdef X_SER_32_BIT_PARITY_EN
    logic             parity_q;
    logic             parity_d;
`endif

    // The final data bit is on the line while the counter sits at WIDTH-1.
    assign last_data = (state_q == DATA) && (cnt_q == LAST_CNT);

    // Ready in IDLE and in the last cycle of a frame so words can go back to back.
`ifdef X_SER_32_BIT_PARITY_EN
    assign o_ready = (state_q == IDLE) || (state_q == PARITY);
`else
    assign o_ready = (state_q == IDLE) || last_data;
`endif

    assign transfer = i_valid && o_ready;
    assign o_busy   = (state_q != IDLE);
    assign o_out    = out_q;

    // Next-state logic. o_out is registered, so out_d is the bit for the next
    // cycle; the shift register therefore runs one bit ahead of the line.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        out_d   = 1'b0;
`ifdef X_SER_32_BIT_PARITY_EN
        parity_d = parity_q;
`endif

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end

            START: begin
                state_d = DATA;
                cnt_d   = '0;
                out_d   = shift_q[WIDTH-1];
                shift_d = {shift_q[WIDTH-2:0], 1'b0};
            end

            DATA: begin
                if (cnt_q == LAST_CNT) begin
`ifdef X_SER_32_BIT_PARITY_EN
                    state_d = PARITY;
                    out_d   = parity_q;
`else
                    state_d = IDLE;
`endif
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    out_d   = shift_q[WIDTH-1];
                    shift_d = {shift_q[WIDTH-2:0], 1'b0};
                end
            end

`ifdef X_SER_32_BIT_PARITY_EN
            PARITY: begin
                state_d = IDLE;
            end
`endif

            default: begin
                state_d = IDLE;
            end
        endcase

        // A handshake only happens in a ready cycle, so it overrides the idle return.
        if (transfer) begin
            state_d = START;
            shift_d = i_data;
            out_d   = 1'b1;
`ifdef X_SER_32_BIT_PARITY_EN
            parity_d = ^i_data;
`endif
        end
    end

    // State, data path and line register; reset abandons any frame in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

`ifdef X_SER_32_BIT_PARITY_EN
    // Parity of the captured word, held until the parity cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

endmodule
